apb_req_arbiter: RTL and testbench

Two-port request arbiter and APB master sequencer that shares one 8-bit APB register-bank slave between two independent requesters. It accepts single-beat read/write requests, grants them round-robin, drives the APB SETUP/ACCESS phases with wait-state and timeout handling, and returns one tagged response per accepted request. It sits between the control-side requesters and the APB register bank that holds registers A–H at addresses 0x00–0x07.

---
 rtl/apb_req_arbiter.sv | 154 +++++++++++++++
 tb/tb_apb_req_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// Two-port round-robin request arbiter driving a single APB master port.
// Each accepted request runs SETUP/ACCESS and returns one tagged response.
module apb_req_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic       pclk,
    input  logic       preset,
    input  logic       req0_valid,
    input  logic       req0_write,
    input  logic [7:0] req0_addr,
    input  logic [7:0] req0_wdata,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_write,
    input  logic [7:0] req1_addr,
    input  logic [7:0] req1_wdata,
    output logic       req1_ready,
    output logic       rsp_valid,
    output logic       rsp_id,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       psel,
    output logic       penable,
    output logic       pwrite,
    output logic [7:0] paddr,
    output logic [7:0] pwdata,
    input  logic [7:0] prdata,
    input  logic       pready,
    input  logic       pslverr
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    state_t     state_q, state_d;
    logic       last_q, last_d;
    logic [7:0] wait_q, wait_d;
    logic       wr_q, wr_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       id_q, id_d;
    logic [7:0] rdata_q, rdata_d;
    logic       err_q, err_d;
    logic       rid_q, rid_d;

    // State and datapath registers; reset leaves the bus idle and port 0 favoured
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            wait_q  <= 8'h00;
            wr_q    <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            id_q    <= 1'b0;
            rdata_q <= 8'h00;
            err_q   <= 1'b0;
            rid_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wait_q  <= wait_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            id_q    <= id_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            rid_q   <= rid_d;
        end
    end

    // Next state: latch the granted request, run the APB phases, capture the result
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        wait_d  = wait_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        id_d    = id_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        rid_d   = rid_q;
        unique case (state_q)
            S_IDLE: begin
                if (req0_ready || req1_ready) begin
                    state_d = S_SETUP;
                    last_d  = req1_ready;
                    id_d    = req1_ready;
                    wr_d    = req1_ready ? req1_write : req0_write;
                    addr_d  = req1_ready ? req1_addr  : req0_addr;
                    wdata_d = req1_ready ? req1_wdata : req0_wdata;
                    wait_d  = 8'h00;
                end
            end
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: begin
                if (pready) begin
                    rdata_d = wr_q ? 8'h00 : prdata;
                    err_d   = pslverr;
                    rid_d   = id_q;
                    state_d = S_RESP;
                end else if (wait_q == TO_LIMIT) begin
                    // counter already holds TIMEOUT stalled cycles: abort
                    rdata_d = 8'h00;
                    err_d   = 1'b1;
                    rid_d   = id_q;
                    state_d = S_RESP;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: grant only in IDLE, the port not granted last wins a tie
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        psel       = 1'b0;
        penable    = 1'b0;
        rsp_valid  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                req0_ready = req0_valid && (!req1_valid || last_q);
                req1_ready = req1_valid && (!req0_valid || !last_q);
            end
            S_SETUP:  psel = 1'b1;
            S_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            S_RESP:   rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign pwrite    = wr_q;
    assign paddr     = addr_q;
    assign pwdata    = wdata_q;
    assign rsp_id    = rid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: APB register-bank slave model plus a
// transaction-level reference for grants, latency and response contents.
module tb_apb_req_arbiter;

    localparam int TO = 4;

    logic       pclk = 1'b0;
    logic       preset;
    logic       req0_valid, req0_write, req0_ready;
    logic [7:0] req0_addr, req0_wdata;
    logic       req1_valid, req1_write, req1_ready;
    logic [7:0] req1_addr, req1_wdata;
    logic       rsp_valid, rsp_id, rsp_err;
    logic [7:0] rsp_rdata;
    logic       psel, penable, pwrite;
    logic [7:0] paddr, pwdata, prdata;
    logic       pready, pslverr;

    int vectors = 0;
    int miscompares = 0;

    apb_req_arbiter #(.TIMEOUT(TO)) dut (
        .pclk(pclk), .preset(preset),
        .req0_valid(req0_valid), .req0_write(req0_write),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_write(req1_write),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    // Slave model: registers A-H at 0x00-0x07, error above, stall_n wait states
    logic       load_bank;
    logic [7:0] bank [0:7];
    int         acc_cnt;
    int         stall_n;

    function automatic logic [7:0] reset_val(input int i);
        logic [63:0] v;
        v = 64'hEFCDAB8967451232;
        return v[i*8 +: 8];
    endfunction

    always @(posedge pclk) begin
        if (load_bank) begin
            for (int i = 0; i < 8; i++) bank[i] <= reset_val(i);
        end else if (psel && penable && pready && pwrite && paddr < 8) begin
            bank[paddr[2:0]] <= pwdata;
        end
    end

    always @(posedge pclk) begin
        if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    assign pready  = psel && penable && (acc_cnt >= stall_n);
    assign prdata  = (paddr < 8) ? bank[paddr[2:0]] : 8'h00;
    assign pslverr = (paddr >= 8);

    // Reference state
    logic [7:0] exp_bank [0:7];
    int         lg_model;

    task automatic set_req(input int port, input logic v, input logic wr,
                           input logic [7:0] a, input logic [7:0] d);
        if (port == 0) begin
            req0_valid = v; req0_write = wr; req0_addr = a; req0_wdata = d;
        end else begin
            req1_valid = v; req1_write = wr; req1_addr = a; req1_wdata = d;
        end
    endtask

    // One request from one port; starts and ends on a falling edge
    task automatic xfer(input string tag, input int port, input logic wr,
                        input logic [7:0] a, input logic [7:0] d,
                        input int stall);
        int n;
        int k;
        int lat;
        bit tmo;
        logic       rdy;
        logic [7:0] er;
        logic       ee;
        stall_n = stall;
        set_req(port, 1'b1, wr, a, d);
        #1;
        n = 0;
        rdy = (port == 0) ? req0_ready : req1_ready;
        while (!rdy && n < 20) begin
            @(negedge pclk); #1;
            n++;
            rdy = (port == 0) ? req0_ready : req1_ready;
        end
        vectors++;
        if (!rdy) begin
            miscompares++;
            $display("FAIL %s accept: ready=%b required 1", tag, rdy);
            set_req(port, 1'b0, 1'b0, 8'h00, 8'h00);
            @(negedge pclk);
            return;
        end
        vectors++;
        if (((port == 0) ? req1_ready : req0_ready) !== 1'b0 || psel !== 1'b0) begin
            miscompares++;
            $display("FAIL %s accept_idle: other_ready=%b psel=%b required 0/0",
                     tag, (port == 0) ? req1_ready : req0_ready, psel);
        end
        lg_model = port;
        tmo = (stall > TO);
        lat = 3 + (tmo ? TO : stall);
        ee  = tmo || (a >= 8);
        er  = (wr || ee) ? 8'h00 : exp_bank[a[2:0]];
        if (wr && !tmo && a < 8) exp_bank[a[2:0]] = d;
        @(negedge pclk);
        set_req(port, 1'b0, 1'b0, 8'h00, 8'h00);
        k = 1;
        vectors++;
        if (psel !== 1'b1 || penable !== 1'b0 || paddr !== a || pwrite !== wr ||
            (wr && pwdata !== d)) begin
            miscompares++;
            $display("FAIL %s setup: psel=%b pen=%b addr=%h wr=%b wd=%h required 1 0 %h %b %h",
                     tag, psel, penable, paddr, pwrite, pwdata, a, wr, d);
        end
        while (rsp_valid !== 1'b1 && k < 40) begin
            @(negedge pclk);
            k++;
            if (k == 2) begin
                vectors++;
                if (psel !== 1'b1 || penable !== 1'b1 || paddr !== a) begin
                    miscompares++;
                    $display("FAIL %s access: psel=%b pen=%b addr=%h required 1 1 %h",
                             tag, psel, penable, paddr, a);
                end
            end
        end
        vectors++;
        if (k != lat || rsp_id !== port[0] || rsp_rdata !== er || rsp_err !== ee) begin
            miscompares++;
            $display("FAIL %s response: lat=%0d id=%b rd=%h err=%b required %0d %b %h %b",
                     tag, k, rsp_id, rsp_rdata, rsp_err, lat, port[0], er, ee);
        end
        @(negedge pclk);
        vectors++;
        if (rsp_valid !== 1'b0 || psel !== 1'b0 || rsp_rdata !== er || rsp_err !== ee) begin
            miscompares++;
            $display("FAIL %s hold: valid=%b psel=%b rd=%h err=%b required 0 0 %h %b",
                     tag, rsp_valid, psel, rsp_rdata, rsp_err, er, ee);
        end
    endtask

    task automatic test_reset();
        load_bank = 1'b1;
        preset = 1'b1;
        stall_n = 0;
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 8; i++) exp_bank[i] = reset_val(i);
        lg_model = 1;
        repeat (3) @(negedge pclk);
        vectors++;
        if ({psel, penable, pwrite, rsp_valid, rsp_id, rsp_err,
             paddr, pwdata, rsp_rdata} !== 30'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: %b required all 0",
                     {psel, penable, pwrite, rsp_valid, rsp_id, rsp_err,
                      paddr, pwdata, rsp_rdata});
        end
        preset = 1'b0;
        load_bank = 1'b0;
        @(negedge pclk);
        vectors++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || psel !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: r0=%b r1=%b psel=%b required 0 0 0",
                     req0_ready, req1_ready, psel);
        end
    endtask

    task automatic test_round_robin();
        int acc = 0;
        int rsp = 0;
        int n = 0;
        int q[$];
        int e;
        int g;
        stall_n = 0;
        set_req(0, 1'b1, 1'b0, 8'h01, 8'h00);
        set_req(1, 1'b1, 1'b0, 8'h02, 8'h00);
        #1;
        while (rsp < 4 && n < 60) begin
            vectors++;
            if (req0_ready && req1_ready) begin
                miscompares++;
                $display("FAIL rr_single_grant: r0=%b r1=%b required one-hot", req0_ready, req1_ready);
            end
            if (req0_ready || req1_ready) begin
                e = 1 - lg_model;
                g = req1_ready ? 1 : 0;
                vectors++;
                if (g != e) begin
                    miscompares++;
                    $display("FAIL rr_grant: port=%0d required %0d", g, e);
                end
                lg_model = g;
                q.push_back(g);
                acc++;
            end
            if (rsp_valid === 1'b1 && q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                if (rsp_id !== e[0] || rsp_err !== 1'b0 ||
                    rsp_rdata !== exp_bank[(e == 0) ? 1 : 2]) begin
                    miscompares++;
                    $display("FAIL rr_response: id=%b rd=%h err=%b required %b %h 0",
                             rsp_id, rsp_rdata, rsp_err, e[0], exp_bank[(e == 0) ? 1 : 2]);
                end
                rsp++;
            end
            @(negedge pclk);
            if (acc >= 4) begin
                set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
                set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
            end
            #1;
            n++;
        end
        vectors++;
        if (rsp != 4) begin
            miscompares++;
            $display("FAIL rr_count: responses=%0d required 4", rsp);
        end
        @(negedge pclk);
    endtask

    task automatic test_reset_mid_access();
        int n = 0;
        stall_n = 255;
        set_req(0, 1'b1, 1'b0, 8'h04, 8'h00);
        #1;
        while (!req0_ready && n < 20) begin
            @(negedge pclk); #1;
            n++;
        end
        lg_model = 0;
        @(negedge pclk);
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge pclk);
        vectors++;
        if (penable !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre: penable=%b required 1", penable);
        end
        #2 preset = 1'b1;
        #1;
        vectors++;
        if (psel !== 1'b0 || penable !== 1'b0 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_async: psel=%b pen=%b rv=%b required 0 0 0",
                     psel, penable, rsp_valid);
        end
        @(negedge pclk);
        preset = 1'b0;
        lg_model = 1;
        @(negedge pclk);
        vectors++;
        if (rsp_valid !== 1'b0 || psel !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_no_resp: rv=%b psel=%b required 0 0", rsp_valid, psel);
        end
        stall_n = 0;
        set_req(0, 1'b1, 1'b0, 8'h00, 8'h00);
        set_req(1, 1'b1, 1'b0, 8'h07, 8'h00);
        #1;
        vectors++;
        if (req0_ready !== (lg_model == 1) || req1_ready !== (lg_model == 0)) begin
            miscompares++;
            $display("FAIL rst_first_grant: r0=%b r1=%b required 1 0", req0_ready, req1_ready);
        end
        lg_model = 0;
        @(negedge pclk);
        set_req(0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_req(1, 1'b0, 1'b0, 8'h00, 8'h00);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            @(negedge pclk);
            n++;
        end
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_rdata !== exp_bank[0]) begin
            miscompares++;
            $display("FAIL rst_after: rv=%b id=%b rd=%h required 1 0 %h",
                     rsp_valid, rsp_id, rsp_rdata, exp_bank[0]);
        end
        @(negedge pclk);
    endtask

    task automatic test_random();
        int port;
        logic wr;
        logic [7:0] a;
        logic [7:0] d;
        int st;
        for (int i = 0; i < 40; i++) begin
            port = $urandom_range(0, 1);
            wr   = 1'($urandom_range(0, 1));
            a    = 8'($urandom_range(0, 11));
            d    = 8'($urandom);
            st   = $urandom_range(0, 6);
            xfer("random", port, wr, a, d, st);
        end
    endtask

    initial begin
        test_reset();
        xfer("read_zero_wait", 0, 1'b0, 8'h00, 8'h00, 0);
        xfer("write_p1", 1, 1'b1, 8'h03, 8'hA5, 0);
        xfer("readback_p1", 1, 1'b0, 8'h03, 8'h00, 0);
        test_round_robin();
        xfer("slverr", 0, 1'b0, 8'h09, 8'h00, 0);
        xfer("wait3", 1, 1'b0, 8'h05, 8'h00, 3);
        xfer("timeout", 0, 1'b0, 8'h06, 8'h00, 255);
        xfer("timeout_wr", 1, 1'b1, 8'h02, 8'h5A, 255);
        xfer("wait_eq_to", 0, 1'b0, 8'h02, 8'h00, TO);
        test_random();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
